receiver_poll_scheduler: RTL and testbench
==========================================

# receiver_poll_scheduler

Round-robin scheduler that sequences readout of the decoded-block RAMs of `NB_RECEIVERS` photodiode receiver channels onto one shared output stream. It sits above the per-receiver managers: it drives each channel's block-select index, waits for the RAM's ready flag, captures the 41-bit block, and presents it tagged with its receiver id to the downstream link via a valid/ready handshake. Only one receiver is addressed at a time; all others see block index 0 (idle).

## Interface
- `NB_RECEIVERS`, default 4: number of receiver channels; must be ≥2.
- `TIMEOUT`, default 15: maximum cycles waited for `data_ready` to rise (WAIT) or fall (RELEASE); must be ≥1.
- `ID_W` (localparam) = max(1, clog2(`NB_RECEIVERS`)).
- `clk_96MHz`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  scanning allowed; sampled only in SCAN.
- `avl_blocks_nb`  in  8·N  per-receiver available-block count; receiver i occupies bits [8i+7:8i].
- `block_wanted`  in  41·N  per-receiver selected block {ts[23:0], data[16:0]}; receiver i occupies bits [41i+40:41i].
- `data_ready`  in  N  per-receiver flag: `block_wanted` is valid for the current nonzero index.
- `block_wanted_number`  out  8·N  per-receiver block index; 0 = none requested.
- `out_block`  out  41  captured block.
- `out_receiver_id`  out  ID_W  receiver index of `out_block`.
- `out_valid`  out  1  `out_block`/`out_receiver_id` valid.
- `out_ready`  in  1  downstream accepts when high with `out_valid`.
- `timeout_err`  out  1  one-cycle pulse on any WAIT or RELEASE timeout.
- `busy`  out  1  high in every state except SCAN.

## Operation
- Registers: `rr_ptr` (ID_W), `blk_cnt` (8, snapshot), `blk_idx` (8), `timer` (4 bits min, wide enough for `TIMEOUT`), output regs.
- States: SCAN, REQ, WAIT, OUT, RELEASE.
- SCAN: if `enable` and `avl_blocks_nb[rr_ptr]` ≠ 0, then `blk_cnt` ← that value, `blk_idx` ← 1, go to REQ. Otherwise `rr_ptr` ← `rr_ptr`+1, wrapping from N−1 to 0. One receiver is examined per cycle.
- REQ: `block_wanted_number[rr_ptr]` ← `blk_idx`; `timer` ← 0; go to WAIT. The index stays held through WAIT and OUT.
- WAIT: if `data_ready[rr_ptr]`, then `out_block` ← `block_wanted[rr_ptr]`, `out_receiver_id` ← `rr_ptr`, `out_valid` ← 1, go to OUT. Else `timer`++. When `timer` reaches `TIMEOUT`: pulse `timeout_err`, index ← 0, `blk_idx` ← `blk_cnt` (abandon the remaining blocks of this receiver), go to RELEASE.
- OUT: hold all outputs stable until `out_valid & out_ready`. On the handshake: `out_valid` ← 0, index ← 0, `timer` ← 0, go to RELEASE.
- RELEASE: wait for `data_ready[rr_ptr]` = 0, or for `timer` = `TIMEOUT` (pulse `timeout_err`). Then:
  - if `blk_idx` < `blk_cnt`: `blk_idx`++, go to REQ;
  - else: `rr_ptr`++ with wrap, go to SCAN.
- `blk_cnt` is a snapshot. Changes to `avl_blocks_nb` during a burst are ignored until the next SCAN visit.
- `enable` deasserting mid-burst does not abort; the burst completes.
- At most one bit-slice of `block_wanted_number` is nonzero at any time.

## Timing
- Reset values: all `block_wanted_number` = 0, `out_block` = 0, `out_receiver_id` = 0, `out_valid` = 0, `timeout_err` = 0, `busy` = 0, state = SCAN, `rr_ptr` = 0.
- `reset` asserted in any state returns to these values on the next edge, dropping any pending `out_valid`. The interrupted block is lost.
- Latencies, with RAM latency L cycles (index driven → `data_ready` high):
  - SCAN hit → index driven: 1 cycle (registered in REQ).
  - SCAN hit → `out_valid`: 2 + L cycles.
  - Handshake → index 0: same edge.
  - Next REQ: 1 cycle after `data_ready` is seen low.
- `out_valid` never drops without a handshake except on reset.
- Empty round: with no receiver pending, `rr_ptr` advances once per cycle; a full cycle of the pointer takes N cycles.
- Fairness: after servicing receiver i, the scan resumes at i+1. This holds even if i has new blocks.

## Test plan
- Single block: N=4, `avl_blocks_nb[2]`=1, RAM model L=2, `out_ready`=1 → `block_wanted_number[2]`=1, then `out_valid` with `out_receiver_id`=2 and the model's block, then index 0. No other slice is ever nonzero.
- Burst with backpressure: receiver 0 has 3 blocks; `out_ready` held low for 5 cycles on block 2 → `out_block` is stable throughout; indices 1, 2, 3 are requested in order; exactly 3 handshakes occur.
- Round-robin: receivers 1 and 3 each have 1 block, `rr_ptr`=0 → service order is 1, then 3. With receiver 1 reloaded after its service, the order is 1, 3, 1.
- Timeout: receiver 2 has 2 blocks and its model never asserts `data_ready` → `timeout_err` pulses once after `TIMEOUT`+1 WAIT cycles. Block 2 is not requested, scanning resumes at receiver 3, and `out_valid` never rises.
- Reset mid-OUT: `out_valid`=1 with `out_ready`=0, then `reset` for 1 cycle → the next cycle shows all outputs 0 and state SCAN with `rr_ptr`=0.
- Enable gating: `enable`=0 with `avl_blocks_nb[0]`=5 → no index is ever driven. Raising `enable` starts a burst within N cycles.

Source files
------------

// File: rtl/receiver_poll_scheduler.sv
// Round-robin readout of per-receiver decoded-block RAMs onto one valid/ready stream.
// Each receiver burst: snapshot its block count, request blocks 1..count in turn, tag each with the receiver id.
module receiver_poll_scheduler #(
  parameter int NB_RECEIVERS = 4,
  parameter int TIMEOUT      = 15,
  localparam int ID_W = ($clog2(NB_RECEIVERS) > 1) ? $clog2(NB_RECEIVERS) : 1
) (
  input  logic                       clk_96MHz,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [8*NB_RECEIVERS-1:0]  avl_blocks_nb,
  input  logic [41*NB_RECEIVERS-1:0] block_wanted,
  input  logic [NB_RECEIVERS-1:0]    data_ready,
  output logic [8*NB_RECEIVERS-1:0]  block_wanted_number,
  output logic [40:0]                out_block,
  output logic [ID_W-1:0]            out_receiver_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       timeout_err,
  output logic                       busy
);

  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [ID_W-1:0]  PTR_LAST = ID_W'(NB_RECEIVERS - 1);

  typedef enum logic [2:0] {SCAN, REQ, WAIT, OUT, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]        blk_cnt_q, blk_cnt_d;
  logic [7:0]        blk_idx_q, blk_idx_d;
  logic [7:0]        idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [40:0]       out_block_q, out_block_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_valid_q, out_valid_d;
  logic              terr_q, terr_d;

  logic [7:0]        avl_sel;
  logic [40:0]       blk_sel;
  logic              rdy_sel;
  logic [ID_W-1:0]   ptr_next;

  // Per-receiver views of the addressed channel
  always_comb begin
    avl_sel             = 8'd0;
    blk_sel             = 41'd0;
    rdy_sel             = 1'b0;
    block_wanted_number = '0;
    for (int i = 0; i < NB_RECEIVERS; i++) begin
      if (rr_ptr_q == ID_W'(i)) begin
        avl_sel                         = avl_blocks_nb[8*i +: 8];
        blk_sel                         = block_wanted[41*i +: 41];
        rdy_sel                         = data_ready[i];
        block_wanted_number[8*i +: 8]   = idx_q;
      end
    end
  end

  assign ptr_next = (rr_ptr_q == PTR_LAST) ? '0 : rr_ptr_q + ID_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    blk_cnt_d   = blk_cnt_q;
    blk_idx_d   = blk_idx_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    out_block_d = out_block_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    terr_d      = 1'b0;
    case (state_q)
      SCAN: begin
        if (enable && avl_sel != 8'd0) begin
          blk_cnt_d = avl_sel;
          blk_idx_d = 8'd1;
          state_d   = REQ;
        end else begin
          rr_ptr_d = ptr_next;
        end
      end
      REQ: begin
        idx_d   = blk_idx_q;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rdy_sel) begin
          out_block_d = blk_sel;
          out_id_d    = rr_ptr_q;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else if (timer_q == TMR_MAX) begin
          // A dead RAM abandons the rest of this receiver's burst
          terr_d    = 1'b1;
          idx_d     = 8'd0;
          blk_idx_d = blk_cnt_q;
          timer_d   = '0;
          state_d   = RELEASE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          idx_d       = 8'd0;
          timer_d     = '0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (!rdy_sel || timer_q == TMR_MAX) begin
          terr_d = rdy_sel;
          if (blk_idx_q < blk_cnt_q) begin
            blk_idx_d = blk_idx_q + 8'd1;
            state_d   = REQ;
          end else begin
            rr_ptr_d = ptr_next;
            state_d  = SCAN;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q     <= SCAN;
      rr_ptr_q    <= '0;
      blk_cnt_q   <= 8'd0;
      blk_idx_q   <= 8'd0;
      idx_q       <= 8'd0;
      timer_q     <= '0;
      out_block_q <= 41'd0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      blk_cnt_q   <= blk_cnt_d;
      blk_idx_q   <= blk_idx_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      out_block_q <= out_block_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      terr_q      <= terr_d;
    end
  end

  assign out_block       = out_block_q;
  assign out_receiver_id = out_id_q;
  assign out_valid       = out_valid_q;
  assign timeout_err     = terr_q;
  assign busy            = (state_q != SCAN);

endmodule

// File: tb/tb_receiver_poll_scheduler.sv
// Directed bench for receiver_poll_scheduler: latency-L RAM model per receiver,
// per-cycle protocol/content checks and hand-computed request/handshake sequences.
module tb_receiver_poll_scheduler;
  localparam int N    = 4;
  localparam int TO   = 15;
  localparam int L    = 2;
  localparam int ID_W = 2;

  logic              clk_96MHz = 1'b0;
  logic              reset, enable, out_ready;
  logic [8*N-1:0]    avl_blocks_nb;
  logic [41*N-1:0]   block_wanted;
  logic [N-1:0]      data_ready;
  logic [8*N-1:0]    block_wanted_number;
  logic [40:0]       out_block;
  logic [ID_W-1:0]   out_receiver_id;
  logic              out_valid, timeout_err, busy;

  receiver_poll_scheduler #(.NB_RECEIVERS(N), .TIMEOUT(TO)) dut (
    .clk_96MHz(clk_96MHz), .reset(reset), .enable(enable),
    .avl_blocks_nb(avl_blocks_nb), .block_wanted(block_wanted), .data_ready(data_ready),
    .block_wanted_number(block_wanted_number), .out_block(out_block),
    .out_receiver_id(out_receiver_id), .out_valid(out_valid), .out_ready(out_ready),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // RAM content: unique per (receiver, block index)
  function automatic logic [40:0] ram_word(input int rx, input int k);
    logic [23:0] ts;
    logic [16:0] d;
    ts = 24'(32'h00A5_0000 + rx * 4096 + k * 17);
    d  = 17'(32'h0001_0000 ^ (rx * 257 + k * 9));
    return {ts, d};
  endfunction

  // Per-receiver RAM: ready L cycles after a nonzero index appears, drops with the index
  int            rcnt[N];
  logic [N-1:0]  dead;

  always @(posedge clk_96MHz) begin
    for (int i = 0; i < N; i++) begin
      if (block_wanted_number[8*i +: 8] == 8'd0) rcnt[i] <= 0;
      else if (rcnt[i] < L)                      rcnt[i] <= rcnt[i] + 1;
    end
  end

  always_comb begin
    data_ready   = '0;
    block_wanted = '0;
    for (int i = 0; i < N; i++) begin
      if (block_wanted_number[8*i +: 8] != 8'd0) begin
        block_wanted[41*i +: 41] = ram_word(i, int'(block_wanted_number[8*i +: 8]));
        data_ready[i]            = (rcnt[i] >= L) && !dead[i];
      end
    end
  end

  // Observation logs (codes are rx*100 + block index)
  int req_code[$], req_cyc[$], hs_code[$];
  int cyc = 0, rise_cyc = -1, to_cyc = -1, to_count = 0, stall_count = 0;
  logic [8*N-1:0]  prev_bwn = '0;
  logic [40:0]     prev_blk = '0;
  logic [ID_W-1:0] prev_id = '0;
  logic            prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1, prev_hs = 1'b0;

  always @(negedge clk_96MHz) begin
    int nz;
    logic [7:0] sel_idx;
    cyc++;
    nz = 0;
    sel_idx = 8'd0;
    for (int i = 0; i < N; i++) begin
      if (block_wanted_number[8*i +: 8] != 8'd0) nz++;
      if (out_receiver_id == ID_W'(i)) sel_idx = block_wanted_number[8*i +: 8];
    end
    if (!reset && !prev_rst) begin
      chk("one_slice", nz <= 1, 64'(nz), 64'd1);
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid == 1'b1, 64'(out_valid), 64'd1);
        chk("hold_block", out_block == prev_blk, 64'(out_block), 64'(prev_blk));
        chk("hold_id", out_receiver_id == prev_id, 64'(out_receiver_id), 64'(prev_id));
      end
      if (prev_hs) begin
        chk("hs_valid_drop", out_valid == 1'b0, 64'(out_valid), 64'd0);
        chk("hs_index_zero", block_wanted_number == '0, 64'(block_wanted_number), 64'd0);
      end
      if (out_valid)
        chk("block_content", out_block == ram_word(int'(out_receiver_id), int'(sel_idx)),
            64'(out_block), 64'(ram_word(int'(out_receiver_id), int'(sel_idx))));
      if (nz != 0 || out_valid) chk("busy_active", busy == 1'b1, 64'(busy), 64'd1);
    end
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (block_wanted_number[8*i +: 8] != 8'd0 &&
            block_wanted_number[8*i +: 8] != prev_bwn[8*i +: 8]) begin
          req_code.push_back(i * 100 + int'(block_wanted_number[8*i +: 8]));
          req_cyc.push_back(cyc);
        end
      end
      if (out_valid && !prev_v) rise_cyc = cyc;
      if (out_valid && out_ready) hs_code.push_back(int'(out_receiver_id) * 100 + int'(sel_idx));
      if (out_valid && !out_ready) stall_count++;
      if (timeout_err) begin
        to_count++;
        to_cyc = cyc;
      end
    end
    prev_bwn = block_wanted_number;
    prev_blk = out_block;
    prev_id  = out_receiver_id;
    prev_v   = out_valid;
    prev_r   = out_ready;
    prev_rst = reset;
    prev_hs  = out_valid && out_ready && !reset;
  end

  // Stimulus helpers
  int seen = 0;
  int bursts_left[N];
  int bp_rx = 0, bp_k = 0, bp_left = 0;

  task automatic tick();
    @(posedge clk_96MHz);
    #1;
  endtask

  function automatic int idx_of(input int rx);
    return int'(block_wanted_number[8*rx +: 8]);
  endfunction

  task automatic clear_logs();
    req_code.delete();
    req_cyc.delete();
    hs_code.delete();
    seen = 0;
    to_count = 0;
    stall_count = 0;
    rise_cyc = -1;
    to_cyc = -1;
  endtask

  task automatic service(input int max_cyc, input int want_hs, input int want_req);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      tick();
      while (seen < req_code.size()) begin
        int rx, k;
        rx = req_code[seen] / 100;
        k  = req_code[seen] % 100;
        if (k == 1 && bursts_left[rx] > 0) begin
          bursts_left[rx]--;
          if (bursts_left[rx] == 0) avl_blocks_nb[8*rx +: 8] = 8'd0;
        end
        seen++;
      end
      if (bp_left > 0 && out_valid && int'(out_receiver_id) == bp_rx && idx_of(bp_rx) == bp_k) begin
        out_ready = 1'b0;
        bp_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (hs_code.size() >= want_hs && req_code.size() >= want_req && !busy) done = 1'b1;
    end
    chk("service_bound", done, 64'(done), 64'd1);
  endtask

  task automatic check_seq(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, got.size() == exp.size(), 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk(nm, got[i] == exp[i], 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_valid"}, out_valid == 1'b0, 64'(out_valid), 64'd0);
    chk({nm, "_block"}, out_block == 41'd0, 64'(out_block), 64'd0);
    chk({nm, "_id"}, out_receiver_id == '0, 64'(out_receiver_id), 64'd0);
    chk({nm, "_terr"}, timeout_err == 1'b0, 64'(timeout_err), 64'd0);
    chk({nm, "_busy"}, busy == 1'b0, 64'(busy), 64'd0);
    chk({nm, "_index"}, block_wanted_number == '0, 64'(block_wanted_number), 64'd0);
  endtask

  initial begin
    int e[$];
    reset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    avl_blocks_nb = '0;
    dead = '0;
    for (int i = 0; i < N; i++) bursts_left[i] = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Single block on receiver 2
    clear_logs();
    avl_blocks_nb[8*2 +: 8] = 8'd1;
    bursts_left[2] = 1;
    service(100, 1, 1);
    e = '{201};
    check_seq("single_req", req_code, e);
    check_seq("single_hs", hs_code, e);
    if (req_cyc.size() > 0)
      chk("single_latency", rise_cyc - req_cyc[0] == L + 1, 64'(rise_cyc - req_cyc[0]), 64'(L + 1));
    else
      chk("single_latency", 1'b0, 64'(rise_cyc), 64'(L + 1));
    chk("single_no_timeout", to_count == 0, 64'(to_count), 64'd0);

    // Burst of 3 on receiver 0 with 5 stall cycles on block 2
    clear_logs();
    avl_blocks_nb[8*0 +: 8] = 8'd3;
    bursts_left[0] = 1;
    bp_rx = 0;
    bp_k = 2;
    bp_left = 5;
    service(200, 3, 3);
    e = '{1, 2, 3};
    check_seq("burst_req", req_code, e);
    check_seq("burst_hs", hs_code, e);
    chk("burst_stalls", stall_count == 5, 64'(stall_count), 64'd5);

    // Reset while a block is presented and not accepted
    clear_logs();
    out_ready = 1'b0;
    avl_blocks_nb[8*0 +: 8] = 8'd1;
    for (int c = 0; c < 50 && !out_valid; c++) tick();
    chk("rst_reach_out", out_valid == 1'b1, 64'(out_valid), 64'd1);
    repeat (2) tick();
    reset = 1'b1;
    avl_blocks_nb = '0;
    tick();
    reset = 1'b0;
    check_idle_outputs("rst_mid_out");
    chk("rst_no_hs", hs_code.size() == 0, 64'(hs_code.size()), 64'd0);
    out_ready = 1'b1;

    // Round-robin from pointer 0: receivers 1 and 3, receiver 1 reloaded
    clear_logs();
    bursts_left[1] = 2;
    bursts_left[3] = 1;
    avl_blocks_nb[8*1 +: 8] = 8'd1;
    avl_blocks_nb[8*3 +: 8] = 8'd1;
    service(300, 3, 3);
    e = '{101, 301, 101};
    check_seq("rr_req", req_code, e);
    check_seq("rr_hs", hs_code, e);

    // Receiver 2 never answers; scan resumes at 3 then 0
    clear_logs();
    dead[2] = 1'b1;
    avl_blocks_nb[8*2 +: 8] = 8'd2;
    avl_blocks_nb[8*3 +: 8] = 8'd1;
    avl_blocks_nb[8*0 +: 8] = 8'd1;
    bursts_left[2] = 1;
    bursts_left[3] = 1;
    bursts_left[0] = 1;
    service(400, 2, 3);
    e = '{201, 301, 1};
    check_seq("to_req", req_code, e);
    e = '{301, 1};
    check_seq("to_hs", hs_code, e);
    chk("to_pulses", to_count == 1, 64'(to_count), 64'd1);
    if (req_cyc.size() > 0)
      chk("to_latency", to_cyc - req_cyc[0] == TO + 1, 64'(to_cyc - req_cyc[0]), 64'(TO + 1));
    else
      chk("to_latency", 1'b0, 64'(to_cyc), 64'(TO + 1));
    dead[2] = 1'b0;

    // Enable gating, then a burst of 5 that survives enable dropping
    clear_logs();
    enable = 1'b0;
    avl_blocks_nb[8*0 +: 8] = 8'd5;
    bursts_left[0] = 1;
    repeat (20) tick();
    chk("gate_no_req", req_code.size() == 0, 64'(req_code.size()), 64'd0);
    chk("gate_idle", busy == 1'b0, 64'(busy), 64'd0);
    enable = 1'b1;
    for (int c = 0; c < N + 2 && req_code.size() == 0; c++) tick();
    chk("gate_start", req_code.size() > 0, 64'(req_code.size()), 64'd1);
    enable = 1'b0;
    service(300, 5, 5);
    e = '{1, 2, 3, 4, 5};
    check_seq("gate_req", req_code, e);
    check_seq("gate_hs", hs_code, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
